// File: rtl/hd44780_read_operation.sv
// HD44780 read bus cycle (RW=1): single busy-flag/address or data reads, plus an
// optional busy-poll mode that repeats BF reads until BF clears or the limit is hit.
module hd44780_read_operation #(
    parameter int T_AS       = 1,
    parameter int T_EH       = 4,
    parameter int T_AH       = 1,
    parameter int T_GAP      = 2,
    parameter int POLL_LIMIT = 4095
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic       i_poll,
    input  logic [7:0] i_db,
    output logic       o_rs,
    output logic       o_rw,
    output logic       o_e,
    output logic       o_rd_active,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_timeout,
    output logic       o_busy
);

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, GAP, DONE} state_t;

    // Timers are loaded with (length - 1) and leave their state when they reach zero.
    localparam logic [3:0]  C_AS    = 4'(T_AS - 1);
    localparam logic [3:0]  C_EH    = 4'(T_EH - 1);
    localparam logic [3:0]  C_AH    = 4'(T_AH - 1);
    localparam logic [3:0]  C_GAP   = 4'(T_GAP - 1);
    localparam logic [11:0] C_LIMIT = 12'(POLL_LIMIT);

    state_t      r_state;
    logic [3:0]  r_tmr;
    logic [11:0] r_pollCnt;
    logic        r_poll;

    assign o_busy = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_tmr       <= 4'd0;
            r_pollCnt   <= 12'd0;
            r_poll      <= 1'b0;
            o_rs        <= 1'b0;
            o_rw        <= 1'b0;
            o_e         <= 1'b0;
            o_rd_active <= 1'b0;
            o_data      <= 8'd0;
            o_valid     <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_poll      <= i_poll;
                        o_rs        <= i_rs & ~i_poll;
                        o_rw        <= 1'b1;
                        o_rd_active <= 1'b1;
                        o_timeout   <= 1'b0;
                        r_pollCnt   <= 12'd0;
                        r_tmr       <= C_AS;
                        r_state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_tmr == 4'd0) begin
                        o_e     <= 1'b1;
                        r_tmr   <= C_EH;
                        r_state <= EHIGH;
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end
                EHIGH: begin
                    // The bus is sampled on the edge that also drops E.
                    if (r_tmr == 4'd0) begin
                        o_e    <= 1'b0;
                        o_data <= i_db;
                        if (r_pollCnt != C_LIMIT) begin
                            r_pollCnt <= r_pollCnt + 12'd1;
                        end
                        r_tmr   <= C_AH;
                        r_state <= HOLD;
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end
                HOLD: begin
                    if (r_tmr == 4'd0) begin
                        o_rw    <= 1'b0;
                        o_rs    <= 1'b0;
                        r_tmr   <= C_GAP;
                        r_state <= GAP;
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end
                GAP: begin
                    if (r_tmr == 4'd0) begin
                        if (r_poll && o_data[7] && (r_pollCnt < C_LIMIT)) begin
                            o_rw    <= 1'b1;
                            r_tmr   <= C_AS;
                            r_state <= SETUP;
                        end else begin
                            o_valid     <= 1'b1;
                            o_timeout   <= r_poll & o_data[7];
                            o_rd_active <= 1'b0;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_tmr <= r_tmr - 4'd1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_read_operation.sv
// Self-checking bench for hd44780_read_operation: table vectors, randomized reads
// against a cycle-window model, abort-by-reset and poll-timeout sequences.
module tb_hd44780_read_operation;

    logic       clk;
    logic       rstN;
    logic       aStart, aRs, aPoll;
    logic [7:0] aDb;
    logic       aORs, aRw, aE, aRdActive, aValid, aTimeout, aBusy;
    logic [7:0] aData;
    logic       bStart, bRs, bPoll;
    logic [7:0] bDb;
    logic       bORs, bRw, bE, bRdActive, bValid, bTimeout, bBusy;
    logic [7:0] bData;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic            rs;
        logic            poll;
        logic [3:0][7:0] dbs;
        int              pulses;
        logic [7:0]      expData;
        logic            expTo;
        int              noise;
    } vec_t;

    vec_t vecs[5];

    hd44780_read_operation dutA (
        .i_clk(clk), .i_reset_n(rstN), .i_start(aStart), .i_rs(aRs), .i_poll(aPoll),
        .i_db(aDb), .o_rs(aORs), .o_rw(aRw), .o_e(aE), .o_rd_active(aRdActive),
        .o_data(aData), .o_valid(aValid), .o_timeout(aTimeout), .o_busy(aBusy)
    );

    hd44780_read_operation #(.POLL_LIMIT(3)) dutB (
        .i_clk(clk), .i_reset_n(rstN), .i_start(bStart), .i_rs(bRs), .i_poll(bPoll),
        .i_db(bDb), .o_rs(bORs), .o_rw(bRw), .o_e(bE), .o_rd_active(bRdActive),
        .o_data(bData), .o_valid(bValid), .o_timeout(bTimeout), .o_busy(bBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Walks the bus values the LCD presents on successive E pulses and stops
    // after a non-poll read, a clear BF, or the poll limit.
    function automatic void refModel(input logic poll, input logic [3:0][7:0] dbs,
                                     input int limit, output int pulses,
                                     output logic [7:0] data, output logic to);
        pulses = 0;
        data   = 8'd0;
        for (int i = 0; i < 4; i++) begin
            pulses++;
            data = dbs[i];
            if (!(poll && data[7] && pulses < limit)) break;
        end
        to = poll & data[7];
    endfunction

    // Starts a read on dutA (called just after a negedge in an idle period) and checks
    // every period: read j occupies periods 8j..8j+7 after the start edge (setup, 4 E-high,
    // hold, 2 gap) and the result strobe follows in period 8*pulses.
    task automatic applyStimulus(input logic rs, input logic poll, input logic [3:0][7:0] dbs,
                                 input int pulses, input logic [7:0] expData,
                                 input logic expTo, input int noise);
        int last;
        int j;
        int ph;
        last = 8 * pulses;
        aRs    = rs;
        aPoll  = poll;
        aDb    = 8'($urandom);
        aStart = 1'b1;
        for (int k = 0; k <= last + 1; k++) begin
            @(negedge clk);
            j  = k / 8;
            ph = k % 8;
            if (k < last) begin
                checkOutput("e", aE, (ph >= 1 && ph <= 4) ? 8'd1 : 8'd0);
                checkOutput("rw", aRw, (ph <= 5) ? 8'd1 : 8'd0);
                if (ph <= 5) checkOutput("rs", aORs, rs & ~poll);
                checkOutput("rdActive", aRdActive, 8'd1);
                checkOutput("valid", aValid, 8'd0);
                checkOutput("busy", aBusy, 8'd1);
            end else if (k == last) begin
                checkOutput("validStrobe", aValid, 8'd1);
                checkOutput("data", aData, expData);
                checkOutput("timeout", aTimeout, expTo);
                checkOutput("rdActiveDone", aRdActive, 8'd0);
                checkOutput("eDone", aE, 8'd0);
                checkOutput("busyDone", aBusy, 8'd1);
            end else begin
                checkOutput("busyIdle", aBusy, 8'd0);
                checkOutput("validIdle", aValid, 8'd0);
                checkOutput("timeoutHeld", aTimeout, expTo);
                checkOutput("dataHeld", aData, expData);
            end
            aDb = (ph == 4 && j < pulses) ? dbs[j] : 8'($urandom);
            if (k > last) begin
                aStart = 1'b0;
            end else if (noise == 1) begin
                aStart = 1'($urandom_range(0, 1));
                aRs    = 1'($urandom_range(0, 1));
                aPoll  = 1'($urandom_range(0, 1));
            end else if (noise == 2) begin
                aStart = (k == 2 || k == 8);
            end else begin
                aStart = 1'b0;
            end
        end
    endtask

    initial begin : watchdog
        #5000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int              pulses;
        logic [7:0]      data;
        logic            to;
        logic [3:0][7:0] dbs;
        logic            poll;
        int              ePulses;
        int              validAt;
        int              validSeen;
        logic            prevE;

        vecs[0] = '{rs: 1'b1, poll: 1'b0, dbs: {8'h00, 8'h00, 8'h00, 8'hA5}, pulses: 1,
                    expData: 8'hA5, expTo: 1'b0, noise: 0};
        vecs[1] = '{rs: 1'b0, poll: 1'b0, dbs: {8'h00, 8'h00, 8'h00, 8'h8C}, pulses: 1,
                    expData: 8'h8C, expTo: 1'b0, noise: 0};
        vecs[2] = '{rs: 1'b0, poll: 1'b1, dbs: {8'h05, 8'h80, 8'h80, 8'h80}, pulses: 4,
                    expData: 8'h05, expTo: 1'b0, noise: 0};
        vecs[3] = '{rs: 1'b1, poll: 1'b0, dbs: {8'h00, 8'h00, 8'h00, 8'h3C}, pulses: 1,
                    expData: 8'h3C, expTo: 1'b0, noise: 2};
        vecs[4] = '{rs: 1'b1, poll: 1'b1, dbs: {8'h00, 8'h00, 8'h00, 8'h7F}, pulses: 1,
                    expData: 8'h7F, expTo: 1'b0, noise: 1};

        rstN = 1'b0;
        aStart = 1'b0; aRs = 1'b0; aPoll = 1'b0; aDb = 8'h00;
        bStart = 1'b0; bRs = 1'b0; bPoll = 1'b0; bDb = 8'h00;
        #1;
        checkOutput("resetE", aE, 8'd0);
        checkOutput("resetRw", aRw, 8'd0);
        checkOutput("resetBusy", aBusy, 8'd0);
        checkOutput("resetData", aData, 8'd0);
        checkOutput("resetValid", aValid, 8'd0);
        checkOutput("resetRdActive", aRdActive, 8'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].rs, vecs[i].poll, vecs[i].dbs, vecs[i].pulses,
                          vecs[i].expData, vecs[i].expTo, vecs[i].noise);
        end

        $display("[TB] randomized reads");
        for (int i = 0; i < 40; i++) begin
            poll = 1'($urandom_range(0, 1));
            for (int b = 0; b < 4; b++) begin
                dbs[b] = 8'($urandom);
                if (poll && $urandom_range(0, 2) != 0) dbs[b][7] = 1'b1;
            end
            if (poll) dbs[3][7] = 1'b0;
            refModel(poll, dbs, 4095, pulses, data, to);
            applyStimulus(1'($urandom_range(0, 1)), poll, dbs, pulses, data, to, 1);
        end

        $display("[TB] reset during E high");
        aRs = 1'b1; aPoll = 1'b0; aDb = 8'h11; aStart = 1'b1;
        @(negedge clk);
        aStart = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("ePreAbort", aE, 8'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abortE", aE, 8'd0);
        checkOutput("abortRw", aRw, 8'd0);
        checkOutput("abortRdActive", aRdActive, 8'd0);
        checkOutput("abortBusy", aBusy, 8'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        validSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (aValid || aBusy) validSeen++;
        end
        checkOutput("noValidAfterAbort", 8'(validSeen), 8'd0);
        dbs = {8'h00, 8'h00, 8'h00, 8'h5A};
        applyStimulus(1'b1, 1'b0, dbs, 1, 8'h5A, 1'b0, 0);

        $display("[TB] poll timeout with limit 3");
        bPoll = 1'b1; bRs = 1'b1; bDb = 8'hFF; bStart = 1'b1;
        ePulses = 0; validAt = -1; prevE = 1'b0;
        for (int k = 0; k < 40 && validAt < 0; k++) begin
            @(negedge clk);
            bStart = 1'b0;
            if (bE && !prevE) ePulses++;
            prevE = bE;
            if (bValid) begin
                validAt = k;
                checkOutput("toData", bData, 8'hFF);
                checkOutput("toFlag", bTimeout, 8'd1);
            end
        end
        checkOutput("toPulses", 8'(ePulses), 8'd3);
        checkOutput("toValidCycle", 8'(validAt), 8'd24);
        @(negedge clk);
        bPoll = 1'b0; bDb = 8'h42; bStart = 1'b1;
        @(negedge clk);
        bStart = 1'b0;
        checkOutput("toClearOnStart", bTimeout, 8'd0);
        validAt = -1;
        for (int k = 1; k < 20 && validAt < 0; k++) begin
            @(negedge clk);
            if (bValid) begin
                validAt = k;
                checkOutput("bData", bData, 8'h42);
                checkOutput("bTimeout", bTimeout, 8'd0);
            end
        end
        checkOutput("bValidCycle", 8'(validAt), 8'd8);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
